// File: rtl/data_mem_pkg.sv
// Shared definitions for the CPU data-memory responder: default geometry,
// access latency, counter width and FSM state encoding.
package data_mem_pkg;

    localparam int DATA_W_DEF        = 8;
    localparam int ADDR_W_DEF        = 8;
    localparam int ACCESS_CYCLES_DEF = 5;

    // Wide enough for ACCESS_CYCLES-1 with ACCESS_CYCLES up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_array.sv
// Word store for the data memory: synchronous write, combinational read,
// whole array cleared asynchronously by reset.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Store update: reset wipes every word, otherwise write when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the CPU load/store interface. A request seen in IDLE is
// latched, held for ACCESS_CYCLES edges in ACCESS, committed (write) or
// returned on READDATA (read), then the block rests one cycle in DONE.
//
// Handshake: BUSYWAIT is combinational and high while a request is pending
// in IDLE or being serviced in ACCESS; it drops in DONE, which is the cycle
// the CPU uses to deassert READ/WRITE. Requests seen in DONE are ignored;
// a request still held in the following IDLE cycle starts a new access.
// ACCESS_CYCLES must lie in 1..15 to fit the 4-bit counter.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITEDATA,
    output logic [DATA_W-1:0] READDATA,
    output logic              BUSYWAIT
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_DONE   = DONE;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    // Current FSM state, kept as a plain named signal so checkers can bind to it.
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;

    logic              req;
    logic              finish;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign req    = READ || WRITE;
    assign finish = (state == S_ACCESS) && (cnt == '0);
    // Reset clears the array asynchronously, so an aborted write never lands.
    assign mem_we = finish && lat_wr;

    // Stall signal: pending request in IDLE or any ACCESS cycle; forced low in reset.
    always_comb begin
        BUSYWAIT = 1'b0;
        if (!RESET) begin
            BUSYWAIT = ((state == S_IDLE) && req) || (state == S_ACCESS);
        end
    end

    // FSM, latency counter, request latches and registered load data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lat_wr   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            READDATA <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        // Simultaneous READ and WRITE is serviced as a write.
                        lat_wr   <= WRITE;
                        lat_addr <= ADDRESS;
                        lat_data <= WRITEDATA;
                        cnt      <= CNT_LOAD;
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!lat_wr) begin
                            READDATA <= mem_rdata;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (CLK),
        .rst   (RESET),
        .we    (mem_we),
        .addr  (lat_addr),
        .wdata (lat_data),
        .rdata (mem_rdata)
    );

endmodule
